// File: rtl/sfp_seq.sv
// Sequencer for a row of SFP accumulate/ReLU lanes: clears the lanes, streams num_acc psum
// vectors from memory into them, optionally applies ReLU, and writes each result out.
//
// state | meaning
// IDLE  | waiting for start; config latched on start
// CLEAR | sfp_reset to all lanes
// ACC   | one psum read per cycle, num_acc cycles
// LAST  | no read; last read data is accumulated
// RELU  | sfp_relu strobe (only if relu was latched)
// WRITE | wr_en with the lane results
// DONE  | one-cycle done pulse
module sfp_seq #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [cnt_bw-1:0]        num_acc,
  input  logic [cnt_bw-1:0]        num_out,
  input  logic                     relu,
  input  logic [addr_bw-1:0]       rd_base,
  input  logic [addr_bw-1:0]       wr_base,
  output logic                     rd_en,
  output logic [addr_bw-1:0]       rd_addr,
  input  logic [col*psum_bw-1:0]   rd_data,
  output logic                     sfp_reset,
  output logic                     sfp_acc,
  output logic                     sfp_relu,
  output logic [col*psum_bw-1:0]   sfp_in,
  input  logic [col*psum_bw-1:0]   sfp_out,
  output logic                     wr_en,
  output logic [addr_bw-1:0]       wr_addr,
  output logic [col*psum_bw-1:0]   wr_data,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {IDLE, CLEAR, ACC, LAST, RELU, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [cnt_bw-1:0]   num_acc_q, num_acc_d;
  logic [cnt_bw-1:0]   acc_rem_q, acc_rem_d;
  logic [cnt_bw-1:0]   out_rem_q, out_rem_d;
  logic                relu_q, relu_d;
  logic                rd_en_q, rd_en_d;
  logic [addr_bw-1:0]  rd_addr_q, rd_addr_d;
  logic [addr_bw-1:0]  wr_addr_q, wr_addr_d;
  logic                sfp_reset_q, sfp_reset_d;
  logic                sfp_acc_q, sfp_acc_d;
  logic                sfp_relu_q, sfp_relu_d;
  logic                wr_en_q, wr_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Outputs are computed for the state being entered so they are registered.
  always_comb begin
    state_d     = state_q;
    num_acc_d   = num_acc_q;
    acc_rem_d   = acc_rem_q;
    out_rem_d   = out_rem_q;
    relu_d      = relu_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    rd_en_d     = 1'b0;
    sfp_reset_d = 1'b0;
    sfp_acc_d   = rd_en_q;
    sfp_relu_d  = 1'b0;
    wr_en_d     = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_acc_d = num_acc;
          out_rem_d = num_out - cnt_bw'(1);
          relu_d    = relu;
          rd_addr_d = rd_base;
          wr_addr_d = wr_base;
          if (num_acc == '0 || num_out == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = CLEAR;
            sfp_reset_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d   = ACC;
        rd_en_d   = 1'b1;
        acc_rem_d = num_acc_q - cnt_bw'(1);
      end
      ACC: begin
        rd_addr_d = rd_addr_q + addr_bw'(1);
        if (acc_rem_q == '0) begin
          state_d = LAST;
        end else begin
          acc_rem_d = acc_rem_q - cnt_bw'(1);
          rd_en_d   = 1'b1;
        end
      end
      LAST: begin
        if (relu_q) begin
          state_d    = RELU;
          sfp_relu_d = 1'b1;
        end else begin
          state_d = WRITE;
          wr_en_d = 1'b1;
        end
      end
      RELU: begin
        state_d = WRITE;
        wr_en_d = 1'b1;
      end
      WRITE: begin
        wr_addr_d = wr_addr_q + addr_bw'(1);
        if (out_rem_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          out_rem_d   = out_rem_q - cnt_bw'(1);
          state_d     = CLEAR;
          sfp_reset_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      num_acc_q   <= '0;
      acc_rem_q   <= '0;
      out_rem_q   <= '0;
      relu_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      sfp_reset_q <= 1'b0;
      sfp_acc_q   <= 1'b0;
      sfp_relu_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_acc_q   <= num_acc_d;
      acc_rem_q   <= acc_rem_d;
      out_rem_q   <= out_rem_d;
      relu_q      <= relu_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      sfp_reset_q <= sfp_reset_d;
      sfp_acc_q   <= sfp_acc_d;
      sfp_relu_q  <= sfp_relu_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign sfp_reset = sfp_reset_q;
  assign sfp_acc   = sfp_acc_q;
  assign sfp_relu  = sfp_relu_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sfp_in    = rd_data;
  assign wr_data   = sfp_out;

endmodule

// File: tb/tb_sfp_seq.sv
// Bench for sfp_seq: behavioural psum memory and SFP lanes, expected writes pushed to a
// scoreboard at launch and compared against the writes the sequencer produces.
module tb_sfp_seq;
  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int ABW = 11;
  localparam int CBW = 8;
  localparam int DW  = COL * PBW;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [CBW-1:0] num_acc = '0;
  logic [CBW-1:0] num_out = '0;
  logic           relu = 1'b0;
  logic [ABW-1:0] rd_base = '0;
  logic [ABW-1:0] wr_base = '0;
  logic           rd_en, sfp_reset, sfp_acc, sfp_relu, wr_en, busy, done;
  logic [ABW-1:0] rd_addr, wr_addr;
  logic [DW-1:0]  rd_data = '0;
  logic [DW-1:0]  sfp_in, wr_data;
  logic [DW-1:0]  lanes = '0;

  sfp_seq #(.col(COL), .psum_bw(PBW), .addr_bw(ABW), .cnt_bw(CBW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_acc(num_acc), .num_out(num_out),
    .relu(relu), .rd_base(rd_base), .wr_base(wr_base), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .sfp_reset(sfp_reset), .sfp_acc(sfp_acc), .sfp_relu(sfp_relu),
    .sfp_in(sfp_in), .sfp_out(lanes), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [2048];

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // SFP lane model: clear, accumulate, or ReLU on the rising edge
  always @(posedge clk) begin
    for (int i = 0; i < COL; i++) begin
      if (sfp_reset)     lanes[i*PBW +: PBW] <= '0;
      else if (sfp_acc)  lanes[i*PBW +: PBW] <= lanes[i*PBW +: PBW] + sfp_in[i*PBW +: PBW];
      else if (sfp_relu && lanes[i*PBW + PBW - 1]) lanes[i*PBW +: PBW] <= '0;
    end
  end

  typedef struct {
    logic [ABW-1:0] addr;
    logic [DW-1:0]  data;
    int             cyc;
  } wr_t;

  wr_t            exp_wr_q[$];
  wr_t            obs_wr_q[$];
  logic [ABW-1:0] obs_rd_q[$];
  int             relu_q[$];
  int cyc, done_cyc, done_cnt, busy_cnt, strobe_cnt, excl_cnt;
  int checks = 0;
  int failures = 0;

  task automatic step();
    wr_t w;
    int  s;
    @(negedge clk);
    cyc++;
    if (wr_en) begin
      w.addr = wr_addr; w.data = wr_data; w.cyc = cyc;
      obs_wr_q.push_back(w);
    end
    if (rd_en) obs_rd_q.push_back(rd_addr);
    if (sfp_relu) relu_q.push_back(cyc);
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
    s = int'(sfp_acc) + int'(sfp_relu) + int'(sfp_reset);
    strobe_cnt += s;
    if (s > 1) excl_cnt++;
  endtask

  task automatic clear_obs();
    exp_wr_q.delete(); obs_wr_q.delete(); obs_rd_q.delete(); relu_q.delete();
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; strobe_cnt = 0; excl_cnt = 0;
  endtask

  task automatic set_psum(input int a, input int v);
    logic [DW-1:0] w;
    for (int i = 1; i < COL; i++) w[i*PBW +: PBW] = PBW'($urandom);
    w[PBW-1:0] = PBW'(v);
    mem[a] = w;
  endtask

  function automatic logic [DW-1:0] exp_vec(input int rb, input int n, input int k, input bit r);
    logic [DW-1:0] v;
    logic [DW-1:0] w;
    v = '0;
    for (int j = 0; j < n; j++) begin
      w = mem[(rb + k*n + j) % 2048];
      for (int i = 0; i < COL; i++) v[i*PBW +: PBW] = v[i*PBW +: PBW] + w[i*PBW +: PBW];
    end
    if (r) for (int i = 0; i < COL; i++) if (v[i*PBW + PBW - 1]) v[i*PBW +: PBW] = '0;
    return v;
  endfunction

  task automatic push_exp(input int n, input int m, input bit r, input int rb, input int wb,
                          input int off);
    wr_t e;
    if (n == 0) return;
    for (int k = 0; k < m; k++) begin
      e.addr = ABW'(wb + k);
      e.data = exp_vec(rb, n, k, r);
      e.cyc  = off + (k + 1) * (n + 3 + int'(r));
      exp_wr_q.push_back(e);
    end
  endtask

  task automatic drive_cfg(input int n, input int m, input bit r, input int rb, input int wb);
    num_acc = CBW'(n); num_out = CBW'(m); relu = r; rd_base = ABW'(rb); wr_base = ABW'(wb);
  endtask

  task automatic launch(input int n, input int m, input bit r, input int rb, input int wb,
                        input int exp_m);
    drive_cfg(n, m, r, rb, wb);
    push_exp(n, exp_m, r, rb, wb, 0);
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i = 0;
    while (done_cnt == 0 && i < limit) begin step(); i++; end
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL done_timeout got=no_done want=done within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_en, rd_addr, sfp_reset, sfp_acc, sfp_relu, wr_en, wr_addr, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0",
               {rd_en, rd_addr, sfp_reset, sfp_acc, sfp_relu, wr_en, wr_addr, busy, done});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, rd_en, wr_en} !== 4'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b want=0000", {busy, done, rd_en, wr_en});
    end
  endtask

  task automatic test_basic(input bit r);
    wr_t e, a;
    clear_obs();
    launch(3, 2, r, 0, 10, 2);
    wait_done(100);
    repeat (2) step();
    checks++;
    if (obs_wr_q.size() !== exp_wr_q.size()) begin
      failures++;
      $display("FAIL basic_wr_count relu=%0d got=%0d want=%0d", r, obs_wr_q.size(), exp_wr_q.size());
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front(); a = obs_wr_q.pop_front();
      checks++;
      if (a.addr !== e.addr || a.data !== e.data || a.cyc !== e.cyc) begin
        failures++;
        $display("FAIL basic_write relu=%0d got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                 r, a.addr, a.data, a.cyc, e.addr, e.data, e.cyc);
      end
    end
    checks++;
    if (done_cyc !== (r ? 15 : 13)) begin
      failures++;
      $display("FAIL basic_done_cycle relu=%0d got=%0d want=%0d", r, done_cyc, r ? 15 : 13);
    end
    checks++;
    if (obs_rd_q.size() !== 6 || obs_rd_q[0] !== 11'd0 || obs_rd_q[5] !== 11'd5) begin
      failures++;
      $display("FAIL basic_reads relu=%0d got count=%0d want count=6 addr 0..5", r, obs_rd_q.size());
    end
    checks++;
    if (r ? (relu_q.size() !== 2 || relu_q[0] !== 6 || relu_q[1] !== 13) : (relu_q.size() !== 0)) begin
      failures++;
      $display("FAIL basic_relu_strobes relu=%0d got count=%0d want=%0d", r, relu_q.size(), r ? 2 : 0);
    end
    checks++;
    if (excl_cnt !== 0) begin
      failures++;
      $display("FAIL basic_exclusive relu=%0d got=%0d want=0", r, excl_cnt);
    end
  endtask

  task automatic test_wrap();
    wr_t e, a;
    clear_obs();
    set_psum(2047, -9);
    launch(1, 1, 0, 2047, 2047, 1);
    wait_done(50);
    repeat (2) step();
    checks++;
    if (obs_wr_q.size() !== 1 || obs_rd_q.size() !== 1 || obs_rd_q[0] !== 11'd2047) begin
      failures++;
      $display("FAIL wrap_counts got wr=%0d rd=%0d want wr=1 rd=1 at 2047", obs_wr_q.size(), obs_rd_q.size());
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front(); a = obs_wr_q.pop_front();
      checks++;
      if (a.addr !== e.addr || a.data !== e.data || a.cyc !== e.cyc) begin
        failures++;
        $display("FAIL wrap_write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                 a.addr, a.data, a.cyc, e.addr, e.data, e.cyc);
      end
    end
    checks++;
    if (rd_addr !== 11'd0 || wr_addr !== 11'd0) begin
      failures++;
      $display("FAIL wrap_addr_after got rd=%0d wr=%0d want rd=0 wr=0", rd_addr, wr_addr);
    end
    checks++;
    if (done_cyc !== 5 || excl_cnt !== 0) begin
      failures++;
      $display("FAIL wrap_done got done=%0d excl=%0d want done=5 excl=0", done_cyc, excl_cnt);
    end
  endtask

  task automatic test_degenerate(input int n, input int m);
    clear_obs();
    launch(n, m, 1, 0, 30, m);
    wait_done(20);
    repeat (3) step();
    checks++;
    if (obs_wr_q.size() !== 0 || obs_rd_q.size() !== 0 || strobe_cnt !== 0) begin
      failures++;
      $display("FAIL degenerate_activity n=%0d m=%0d got wr=%0d rd=%0d strobes=%0d want 0 0 0",
               n, m, obs_wr_q.size(), obs_rd_q.size(), strobe_cnt);
    end
    checks++;
    if (done_cyc !== 1 || busy_cnt !== 1 || done_cnt !== 1) begin
      failures++;
      $display("FAIL degenerate_timing n=%0d m=%0d got done=%0d busy=%0d want done=1 busy=1",
               n, m, done_cyc, busy_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    wr_t e, a;
    clear_obs();
    launch(3, 2, 0, 0, 10, 2);
    repeat (2) step();
    drive_cfg(1, 1, 1, 100, 200);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(100);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    checks++;
    if (obs_wr_q.size() !== exp_wr_q.size()) begin
      failures++;
      $display("FAIL busy_start_wr_count got=%0d want=%0d", obs_wr_q.size(), exp_wr_q.size());
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front(); a = obs_wr_q.pop_front();
      checks++;
      if (a.addr !== e.addr || a.data !== e.data || a.cyc !== e.cyc) begin
        failures++;
        $display("FAIL busy_start_write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                 a.addr, a.data, a.cyc, e.addr, e.data, e.cyc);
      end
    end
    checks++;
    if (done_cyc !== 13 || done_cnt !== 1 || busy_cnt !== 13) begin
      failures++;
      $display("FAIL busy_start_timing got done=%0d dones=%0d busy=%0d want done=13 dones=1 busy=13",
               done_cyc, done_cnt, busy_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    wr_t e, a;
    clear_obs();
    launch(3, 2, 0, 0, 10, 1);
    while (cyc < 8) step();
    reset = 1'b0;
    #1;
    checks++;
    if ({rd_en, rd_addr, sfp_reset, sfp_acc, sfp_relu, wr_en, wr_addr, busy, done} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b want=0",
               {rd_en, rd_addr, sfp_reset, sfp_acc, sfp_relu, wr_en, wr_addr, busy, done});
    end
    repeat (3) step();
    reset = 1'b1;
    repeat (4) step();
    checks++;
    if (obs_wr_q.size() !== 1 || obs_rd_q.size() !== 4 || done_cnt !== 0) begin
      failures++;
      $display("FAIL midreset_abort got wr=%0d rd=%0d done=%0d want wr=1 rd=4 done=0",
               obs_wr_q.size(), obs_rd_q.size(), done_cnt);
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front(); a = obs_wr_q.pop_front();
      checks++;
      if (a.addr !== e.addr || a.data !== e.data || a.cyc !== e.cyc) begin
        failures++;
        $display("FAIL midreset_first_write got addr=%0d data=%h want addr=%0d data=%h",
                 a.addr, a.data, e.addr, e.data);
      end
    end
    clear_obs();
    set_psum(0, 3);
    set_psum(1, 4);
    launch(2, 1, 0, 0, 20, 1);
    wait_done(50);
    repeat (2) step();
    checks++;
    if (obs_wr_q.size() !== 1 || done_cyc !== 6) begin
      failures++;
      $display("FAIL midreset_rerun got wr=%0d done=%0d want wr=1 done=6", obs_wr_q.size(), done_cyc);
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front(); a = obs_wr_q.pop_front();
      checks++;
      if (a.addr !== e.addr || a.data !== e.data || a.cyc !== e.cyc || a.data[PBW-1:0] !== 16'd7) begin
        failures++;
        $display("FAIL midreset_rerun_write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                 a.addr, a.data, a.cyc, e.addr, e.data, e.cyc);
      end
    end
    checks++;
    if (excl_cnt !== 0) begin
      failures++;
      $display("FAIL midreset_exclusive got=%0d want=0", excl_cnt);
    end
  endtask

  task automatic test_back_to_back();
    wr_t e, a;
    clear_obs();
    set_psum(50, 1234);
    drive_cfg(1, 1, 0, 50, 60);
    push_exp(1, 1, 0, 50, 60, 0);
    push_exp(1, 1, 0, 50, 60, 6);
    start = 1'b1;
    cyc = 0;
    repeat (10) step();
    start = 1'b0;
    repeat (5) step();
    checks++;
    if (done_cnt !== 2 || done_cyc !== 11 || obs_wr_q.size() !== 2) begin
      failures++;
      $display("FAIL b2b_timing got dones=%0d last_done=%0d wr=%0d want dones=2 last_done=11 wr=2",
               done_cnt, done_cyc, obs_wr_q.size());
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front(); a = obs_wr_q.pop_front();
      checks++;
      if (a.addr !== e.addr || a.data !== e.data || a.cyc !== e.cyc) begin
        failures++;
        $display("FAIL b2b_write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                 a.addr, a.data, a.cyc, e.addr, e.data, e.cyc);
      end
    end
  endtask

  initial begin
    clear_obs();
    cyc = 0;
    set_psum(0, 5);
    set_psum(1, -2);
    set_psum(2, 4);
    set_psum(3, 1);
    set_psum(4, -7);
    set_psum(5, 2);
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_wrap();
    test_degenerate(0, 4);
    test_degenerate(2, 0);
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
